// File: rtl/rc4_pkg.sv
// Purpose: shared encodings and constants for the RC4 key-scheduling and PRGA/decrypt FSMs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rc4_pkg;

    // Synchronous S RAM / ROM: q is valid two cycles after the address is driven,
    // which is why every read walks through issue, wait and latch states.
    localparam int RAM_RD_LAT = 2;

    // Default message length in bytes (legal range 1..256).
    localparam int MSG_LEN_DFLT = 32;

    // Cycles spent per message byte, INC_I through WR_D inclusive.
    localparam int PRGA_BYTE_CYCLES = 14;

    typedef enum logic [3:0] {
        PR_IDLE     = 4'd0,
        PR_INC_I    = 4'd1,
        PR_RD_SI    = 4'd2,
        PR_WAIT_SI  = 4'd3,
        PR_LATCH_SI = 4'd4,
        PR_CALC_J   = 4'd5,
        PR_RD_SJ    = 4'd6,
        PR_WAIT_SJ  = 4'd7,
        PR_LATCH_SJ = 4'd8,
        PR_WR_J     = 4'd9,
        PR_WR_I     = 4'd10,
        PR_RD_F     = 4'd11,
        PR_WAIT_F   = 4'd12,
        PR_LATCH_F  = 4'd13,
        PR_WR_D     = 4'd14,
        PR_DONE     = 4'd15
    } prga_state_t;

endpackage

// File: rtl/rc4_prga_decrypt.sv
// Purpose: RC4 PRGA over the key-scheduled S RAM, XORing keystream with the encrypted ROM into the decrypted RAM.
// Latency: 14 cycles per message byte; done rises 14*MSG_LEN+1 cycles after start is sampled in IDLE.
// Backpressure: none; memories are always ready, start is a level handshake and is ignored mid-run until DONE.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DFLT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] s_q,
    output logic [7:0] s_addr,
    output logic [7:0] s_data,
    output logic       s_wren,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_q,
    output logic [7:0] d_addr,
    output logic [7:0] d_data,
    output logic       d_wren,
    output logic       busy,
    output logic       done
);

    // Index of the final message byte; k never needs to count past it.
    localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

    prga_state_t state;
    prga_state_t state_nxt;

    logic [7:0] i;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] si;
    logic [7:0] sj;
    logic [7:0] f;
    logic [7:0] e;

    // Pre-swap si+sj: the sum is the same after the swap, so no re-read of S[i]/S[j] is needed.
    logic [7:0] f_idx;
    assign f_idx = si + sj;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: each one is loaded in exactly one state of the byte loop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i  <= '0;
            j  <= '0;
            k  <= '0;
            si <= '0;
            sj <= '0;
            f  <= '0;
            e  <= '0;
        end else begin
            case (state)
                PR_INC_I:    i  <= i + 8'd1;
                PR_LATCH_SI: si <= s_q;
                PR_CALC_J:   j  <= j + si;
                PR_LATCH_SJ: sj <= s_q;
                PR_LATCH_F: begin
                    f <= s_q;
                    e <= rom_q;
                end
                PR_WR_D: begin
                    if (k != K_LAST) begin
                        k <= k + 8'd1;
                    end
                end
                PR_DONE: begin
                    // Leaving DONE re-arms the generator for the next message.
                    if (!start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and memory-port decode; addresses are held through the wait and latch states.
    always_comb begin
        state_nxt = state;
        s_addr    = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        rom_addr  = '0;
        d_addr    = '0;
        d_data    = '0;
        d_wren    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state)
            PR_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = PR_INC_I;
                end
            end
            PR_INC_I: begin
                state_nxt = PR_RD_SI;
            end
            PR_RD_SI: begin
                s_addr    = i;
                state_nxt = PR_WAIT_SI;
            end
            PR_WAIT_SI: begin
                s_addr    = i;
                state_nxt = PR_LATCH_SI;
            end
            PR_LATCH_SI: begin
                s_addr    = i;
                state_nxt = PR_CALC_J;
            end
            PR_CALC_J: begin
                state_nxt = PR_RD_SJ;
            end
            PR_RD_SJ: begin
                s_addr    = j;
                state_nxt = PR_WAIT_SJ;
            end
            PR_WAIT_SJ: begin
                s_addr    = j;
                state_nxt = PR_LATCH_SJ;
            end
            PR_LATCH_SJ: begin
                s_addr    = j;
                state_nxt = PR_WR_J;
            end
            PR_WR_J: begin
                // When i==j both writes store the same byte, leaving S unchanged.
                s_addr    = j;
                s_data    = si;
                s_wren    = 1'b1;
                state_nxt = PR_WR_I;
            end
            PR_WR_I: begin
                s_addr    = i;
                s_data    = sj;
                s_wren    = 1'b1;
                state_nxt = PR_RD_F;
            end
            PR_RD_F: begin
                s_addr    = f_idx;
                rom_addr  = k;
                state_nxt = PR_WAIT_F;
            end
            PR_WAIT_F: begin
                s_addr    = f_idx;
                rom_addr  = k;
                state_nxt = PR_LATCH_F;
            end
            PR_LATCH_F: begin
                s_addr    = f_idx;
                rom_addr  = k;
                state_nxt = PR_WR_D;
            end
            PR_WR_D: begin
                d_addr = k;
                d_data = f ^ e;
                d_wren = 1'b1;
                if (k == K_LAST) begin
                    state_nxt = PR_DONE;
                end else begin
                    state_nxt = PR_INC_I;
                end
            end
            PR_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) begin
                    state_nxt = PR_IDLE;
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = PR_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Purpose: directed bench for rc4_prga_decrypt with three instances (MSG_LEN 3, 1, 256) and 2-cycle RAM/ROM models.
// Latency: checks 14-cycle byte timing and done at 14*MSG_LEN+1 cycles after start is sampled.
// Backpressure: n/a; every wait on the DUT is bounded by a cycle budget.
module tb_rc4_prga_decrypt;

    logic clk;
    logic reset_n;

    logic [2:0]      start;
    logic [2:0][7:0] s_q;
    logic [2:0][7:0] s_addr;
    logic [2:0][7:0] s_data;
    logic [2:0]      s_wren;
    logic [2:0][7:0] rom_addr;
    logic [2:0][7:0] rom_q;
    logic [2:0][7:0] d_addr;
    logic [2:0][7:0] d_data;
    logic [2:0]      d_wren;
    logic [2:0]      busy;
    logic [2:0]      done;

    // Memory models (one set per instance) and a bench-side load port.
    logic [7:0] s_mem   [0:2][0:255];
    logic [7:0] enc_mem [0:2][0:255];
    logic [7:0] dec_mem [0:2][0:255];
    logic [2:0][7:0] s_ar;
    logic [2:0][7:0] r_ar;
    logic [2:0] ld_all;
    logic [2:0] ld_s_only;
    logic [7:0] ld_addr;
    logic [7:0] ld_s;
    logic [7:0] ld_e;

    int n_checks;
    int n_errors;

    // Reference RC4 state for the 256-byte run.
    logic [7:0] ms [0:255];
    logic [7:0] ks [0:255];
    logic [7:0] mi, mj, mt, msum;

    rc4_prga_decrypt #(.MSG_LEN(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .s_q(s_q[0]),
        .s_addr(s_addr[0]), .s_data(s_data[0]), .s_wren(s_wren[0]),
        .rom_addr(rom_addr[0]), .rom_q(rom_q[0]), .d_addr(d_addr[0]),
        .d_data(d_data[0]), .d_wren(d_wren[0]), .busy(busy[0]), .done(done[0])
    );

    rc4_prga_decrypt #(.MSG_LEN(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .s_q(s_q[1]),
        .s_addr(s_addr[1]), .s_data(s_data[1]), .s_wren(s_wren[1]),
        .rom_addr(rom_addr[1]), .rom_q(rom_q[1]), .d_addr(d_addr[1]),
        .d_data(d_data[1]), .d_wren(d_wren[1]), .busy(busy[1]), .done(done[1])
    );

    rc4_prga_decrypt #(.MSG_LEN(256)) u_dut256 (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .s_q(s_q[2]),
        .s_addr(s_addr[2]), .s_data(s_data[2]), .s_wren(s_wren[2]),
        .rom_addr(rom_addr[2]), .rom_q(rom_q[2]), .d_addr(d_addr[2]),
        .d_data(d_data[2]), .d_wren(d_wren[2]), .busy(busy[2]), .done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories: registered address then registered data (2-cycle read), write-first storage.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            s_ar[g]  <= s_addr[g];
            s_q[g]   <= s_mem[g][s_ar[g]];
            r_ar[g]  <= rom_addr[g];
            rom_q[g] <= enc_mem[g][r_ar[g]];
            if (s_wren[g]) s_mem[g][s_addr[g]] <= s_data[g];
            if (d_wren[g]) dec_mem[g][d_addr[g]] <= d_data[g];
            if (ld_all[g]) begin
                s_mem[g][ld_addr]   <= ld_s;
                enc_mem[g][ld_addr] <= ld_e;
                dec_mem[g][ld_addr] <= 8'hEE;
            end
            if (ld_s_only[g]) s_mem[g][ld_addr] <= ld_s;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Identity S, enc[a] = base + a*step, dec pre-filled with 0xEE.
    task automatic fill(input int g, input int e_base, input int e_step);
        for (int a = 0; a < 256; a++) begin
            ld_addr   = a[7:0];
            ld_s      = a[7:0];
            ld_e      = 8'(e_base + a * e_step);
            ld_all[g] = 1'b1;
            @(posedge clk);
            #1;
        end
        ld_all[g] = 1'b0;
    endtask

    task automatic poke_s(input int g, input logic [7:0] a, input logic [7:0] v);
        ld_addr      = a;
        ld_s         = v;
        ld_s_only[g] = 1'b1;
        @(posedge clk);
        #1;
        ld_s_only[g] = 1'b0;
    endtask

    // Count cycles from the edge that samples start until done is seen.
    task automatic run_until_done(input int g, input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done[g]) break;
        end
        check($sformatf("done_reached_%0d", g), {31'd0, done[g]}, 32'd1);
    endtask

    task automatic stop_run(input int g);
        start[g] = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("idle_after_stop_%0d", g), {30'd0, done[g], busy[g]}, 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        int first_wr;
        int first_done;
        logic busy14;
        logic busy15;
        int held;
        int sdiff;

        n_checks  = 0;
        n_errors  = 0;
        start     = '0;
        ld_all    = '0;
        ld_s_only = '0;
        ld_addr   = '0;
        ld_s      = '0;
        ld_e      = '0;
        reset_n   = 1'b0;

        // Reset state: every output of every instance is zero.
        #3;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset_outs_%0d", g),
                  {s_addr[g], s_data[g], rom_addr[g], d_addr[g]}, 32'd0);
            check($sformatf("reset_ctl_%0d", g),
                  {21'd0, d_data[g], s_wren[g], d_wren[g], busy[g], done[g]}, 32'd0);
        end
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity S, enc all zero, MSG_LEN=3.
        fill(0, 0, 0);
        start[0] = 1'b1;
        run_until_done(0, 100, cyc);
        check("len3_cycles", cyc, 43);
        check("len3_dec0", dec_mem[0][0], 8'h02);
        check("len3_dec1", dec_mem[0][1], 8'h05);
        check("len3_dec2", dec_mem[0][2], 8'h07);
        check("len3_dec3_untouched", dec_mem[0][3], 8'hEE);
        check("len3_s1", s_mem[0][1], 8'h01);
        check("len3_s2", s_mem[0][2], 8'h03);
        check("len3_s3", s_mem[0][3], 8'h05);
        check("len3_s5", s_mem[0][5], 8'h02);
        check("len3_busy_at_done", busy[0], 0);
        stop_run(0);

        // Identity S, enc all 0xFF.
        fill(0, 8'hFF, 0);
        start[0] = 1'b1;
        run_until_done(0, 100, cyc);
        check("ff_dec0", dec_mem[0][0], 8'hFD);
        check("ff_dec1", dec_mem[0][1], 8'hFA);
        check("ff_dec2", dec_mem[0][2], 8'hF8);
        stop_run(0);

        // Reset at cycle 20 of a run, then a full rerun with start held high.
        fill(0, 8'h3C, 0);
        start[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("pre_reset_busy", busy[0], 1);
        check("pre_reset_s_addr_j", s_addr[0], 8'h03);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrun_reset_outs", {s_addr[0], s_data[0], rom_addr[0], d_addr[0]}, 32'd0);
        check("midrun_reset_ctl",
              {21'd0, d_data[0], s_wren[0], d_wren[0], busy[0], done[0]}, 32'd0);
        #3;
        reset_n = 1'b1;
        run_until_done(0, 100, cyc);
        check("rerun_cycles", cyc, 43);
        check("rerun_dec0", dec_mem[0][0], 8'h3E);
        check("rerun_dec1", dec_mem[0][1], 8'h39);
        check("rerun_dec2", dec_mem[0][2], 8'h3B);
        stop_run(0);

        // MSG_LEN=1 cycle check: single d_wren at cycle 14, done at 15 with busy falling.
        fill(1, 8'h40, 0);
        pulses     = 0;
        first_wr   = 0;
        first_done = 0;
        busy14     = 1'b0;
        busy15     = 1'b1;
        start[1]   = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (d_wren[1]) begin
                pulses++;
                if (first_wr == 0) first_wr = n;
            end
            if (done[1] && first_done == 0) first_done = n;
            if (n == 14) busy14 = busy[1];
            if (n == 15) busy15 = busy[1];
        end
        check("len1_wren_pulses", pulses, 1);
        check("len1_first_wren", first_wr, 14);
        check("len1_first_done", first_done, 15);
        check("len1_busy_c14", busy14, 1);
        check("len1_busy_c15", busy15, 0);
        check("len1_dec0", dec_mem[1][0], 8'h42);
        stop_run(1);

        // i==j: S[1]=1 gives j=1=i; swap is a no-op and f=S[2].
        fill(1, 8'h0F, 0);
        poke_s(1, 8'd2, 8'h5A);
        start[1] = 1'b1;
        run_until_done(1, 50, cyc);
        check("ieqj_dec0", dec_mem[1][0], 8'h55);
        check("ieqj_s1", s_mem[1][1], 8'h01);
        check("ieqj_s2", s_mem[1][2], 8'h5A);
        stop_run(1);

        // MSG_LEN=256 against a software RC4 PRGA (i wraps to 0 on the last byte).
        for (int a = 0; a < 256; a++) ms[a] = a[7:0];
        mi = 8'd0;
        mj = 8'd0;
        for (int kk = 0; kk < 256; kk++) begin
            mi     = mi + 8'd1;
            mj     = mj + ms[mi];
            mt     = ms[mi];
            ms[mi] = ms[mj];
            ms[mj] = mt;
            msum   = ms[mi] + ms[mj];
            ks[kk] = ms[msum];
        end
        fill(2, 3, 7);
        start[2] = 1'b1;
        run_until_done(2, 5000, cyc);
        check("len256_cycles", cyc, 14 * 256 + 1);
        for (int kk = 0; kk < 256; kk++) begin
            check($sformatf("len256_dec%0d", kk), dec_mem[2][kk], ks[kk] ^ 8'(3 + kk * 7));
        end
        sdiff = 0;
        for (int a = 0; a < 256; a++) begin
            if (s_mem[2][a] !== ms[a]) sdiff++;
        end
        check("len256_final_s_diffs", sdiff, 0);
        held = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done[2]) held++;
        end
        check("len256_done_held", held, 8);
        stop_run(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rc4_prga_decrypt.md
# rc4_prga_decrypt

Second RC4 stage: runs the pseudo-random generation algorithm over the key-scheduled S memory and XORs each keystream byte with the encrypted message ROM, writing plaintext to the decrypted-message RAM. Sits directly downstream of the key-scheduling FSM and shares the S RAM port with it. It starts when key scheduling reports completion and raises `done` after the last message byte is written.

## Interface
- `MSG_LEN`, 32: message length in bytes, 1..256.
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: level; key scheduling complete; S RAM ownership passes to this block.
- `s_q` input 8: S RAM read data.
- `s_addr` output 8: S RAM address.
- `s_data` output 8: S RAM write data.
- `s_wren` output 1: S RAM write enable.
- `rom_addr` output 8: encrypted ROM address (k).
- `rom_q` input 8: encrypted ROM read data.
- `d_addr` output 8: decrypted RAM address (k).
- `d_data` output 8: decrypted RAM write data.
- `d_wren` output 1: decrypted RAM write enable.
- `busy` output 1: high from leaving IDLE until reaching DONE.
- `done` output 1: high while in DONE.

## Operation
- Algorithm: i=0, j=0; for k=0..MSG_LEN-1: i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[S[i]+S[j]]; dec[k]=f^enc[k]. All index arithmetic is 8-bit, mod 256, with natural wrap.
- Memory model: S RAM and ROM are synchronous. Data is valid in `q` two cycles after the address is driven. Each read therefore uses three states: issue, wait, latch.
- FSM states and transitions:
  - IDLE: go to INC_I when `start`=1.
  - INC_I: i<=i+1.
  - RD_SI (`s_addr`=i), WAIT_SI, LATCH_SI: si<=s_q.
  - CALC_J: j<=j+si.
  - RD_SJ (`s_addr`=j), WAIT_SJ, LATCH_SJ: sj<=s_q.
  - WR_J: `s_addr`=j, `s_data`=si, `s_wren`=1.
  - WR_I: `s_addr`=i, `s_data`=sj, `s_wren`=1.
  - RD_F: `s_addr`=si+sj, `rom_addr`=k.
  - WAIT_F.
  - LATCH_F: f<=s_q, e<=rom_q.
  - WR_D: `d_addr`=k, `d_data`=f^e, `d_wren`=1. If k==MSG_LEN-1, go to DONE; else k<=k+1 and go to INC_I.
  - DONE: hold. Go to IDLE when `start`=0; i, j and k clear on that transition.
- The f index uses the pre-swap si+sj. This is equivalent to the post-swap values and avoids a re-read.
- i==j case: both writes store the same value, so S is unchanged. No special handling.
- `start` deasserting mid-run is ignored until DONE.
- Write enables are asserted only in WR_J, WR_I and WR_D. All addresses and data are combinational from the state and registers.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - state=IDLE.
  - i, j, k, si, sj, f and e cleared.
  - All outputs 0: `s_wren`=`d_wren`=`busy`=`done`=0, addresses 0, data 0.
- Latency: `start` high in IDLE leads to INC_I on the next edge. Each byte takes exactly 14 cycles (INC_I..WR_D).
- First `d_wren` occurs 14 cycles after leaving IDLE. `done` rises 14·MSG_LEN+1 cycles after `start` is sampled.
- Read-after-write ordering: RD_F follows WR_I by one cycle, and INC_I of the next byte follows WR_D. The RAM must complete writes in the write cycle, so a later read of the same address returns the new value.
- Reset mid-operation returns to IDLE immediately. Partial S/decrypted contents are left as-is and are not the block's concern.

## Structure
- Shared package `rc4_pkg`:
  - state enum `prga_state_t`.
  - `RAM_RD_LAT`=2.
  - default `MSG_LEN`.
  - Also reused by the key-scheduling FSM for its encodings.
- Single module with no sub-module. The S RAM address/data mux to the arbiter is owned by the top level.

## Test plan
- Identity S (S[x]=x), enc all 0x00, MSG_LEN=3 -> dec = 0x02, 0x05, 0x07. S[2]=3, S[3]=5, S[5]=2 after completion.
- Identity S, enc = 0xFF repeated -> dec = 0xFD, 0xFA, 0xF8 (keystream XOR).
- Cycle check, MSG_LEN=1: `d_wren` pulses exactly once, 14 cycles after start. `done` is high on the next cycle and `busy` falls with it.
- i==j case: S[1]=0 with identity elsewhere gives j=0+0=0≠1. Use S[1]=1 with j forced back to 1 via a prior state so that i==j. S is unchanged by the swap and the f read is correct.
- Reset asserted at cycle 20 of a run -> all outputs 0 asynchronously. After release with `start` high, a full run gives correct output from k=0.
- MSG_LEN=256 with a wrap scenario (si+sj > 255, i wraps at byte 255) -> matches the software RC4 model byte-for-byte. `done` is held while `start` stays high and the FSM returns to IDLE when `start` drops.
